// File: rtl/spi_pkg.sv
// Shared command codes and FSM state encoding for the SPI-attached RAM.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/spi_ram_array.sv
// MEM_DEPTH x 8 storage: synchronous write, registered read, contents never reset.
module spi_ram_array #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [7:0] mem [MEM_DEPTH];

  // Callers gate both enables with a range check, so only the low index bits matter here.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr[IDX_W-1:0]];
  end

endmodule

// File: rtl/spi_ram.sv
// Command-decoding RAM fed by the SPI slave's 10-bit word; returns read bytes on dout/tx_valid.
// Optional build macro SPI_RAM_AUTOINC_EN: post-increment wr_addr on cmd 01 and rd_addr on cmd 11.
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] LAST_L  = DEPTH_L - 1'b1;

  state_t                 state, state_nx;
  logic                   rx_valid_d;
  logic                   accept;
  logic [1:0]             cmd;
  logic [ADDR_SIZE-1:0]   payload;
  logic [ADDR_SIZE-1:0]   wr_addr, rd_addr;
  logic                   wr_in_range, rd_in_range;
  logic                   wr_en, rd_en;
  logic                   rd_oor;
  logic [7:0]             rd_data;
  logic                   load_out, clr_tx;

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return ({1'b0, a} >= LAST_L) ? '0 : a + 1'b1;
  endfunction
`endif

  assign accept      = rx_valid & ~rx_valid_d;
  assign cmd         = din[9:8];
  assign payload     = din[ADDR_SIZE-1:0];
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
  assign wr_en       = accept && (cmd == CMD_WR_DATA) && wr_in_range;
  assign rd_en       = accept && (cmd == CMD_RD_DATA) && rd_in_range;

  spi_ram_array #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(din[7:0]),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A new read from HOLD goes straight back to READ so tx_valid drops for exactly one cycle.
  always_comb begin
    state_nx = state;
    load_out = 1'b0;
    clr_tx   = 1'b0;
    case (state)
      IDLE: if (accept && cmd == CMD_RD_DATA) state_nx = READ;
      READ: begin
        load_out = 1'b1;
        state_nx = HOLD;
      end
      HOLD: if (accept) begin
        clr_tx   = 1'b1;
        state_nx = (cmd == CMD_RD_DATA) ? READ : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_d <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      rd_oor     <= 1'b0;
      dout       <= 8'h00;
      tx_valid   <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      if (accept) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= payload;
`ifdef SPI_RAM_AUTOINC_EN
          CMD_WR_DATA: wr_addr <= next_addr(wr_addr);
`endif
          CMD_RD_ADDR: rd_addr <= payload;
          CMD_RD_DATA: begin
            rd_oor <= ~rd_in_range;
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr <= next_addr(rd_addr);
`endif
          end
          default: ;
        endcase
      end
      if (load_out) begin
        dout     <= rd_oor ? 8'h00 : rd_data;
        tx_valid <= 1'b1;
      end else if (clr_tx) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram.sv
// Bench for spi_ram: two instances (depth 256 and 128) share one randomized word stream
// and are checked every cycle against a transaction-level model, plus directed literal checks.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout0, dout1;
  logic       tx0, tx1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout0), .tx_valid(tx0)
  );

  spi_ram #(.MEM_DEPTH(128), .ADDR_SIZE(8)) dut_s (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout1), .tx_valid(tx1)
  );

  // Reference model: per instance, the memory image, address pointers and the pending read.
  int         depth [2] = '{256, 128};
  logic [7:0] m_mem   [2][256];
  bit         m_known [2][256];
  int         m_wa [2], m_ra [2];
  bit         m_tx [2], m_dknown [2], m_pend [2], m_pknown [2];
  logic [7:0] m_dout [2], m_pval [2];
  bit         m_rxp;

  function automatic int nxt(int a, int d);
    return (a >= d - 1) ? 0 : a + 1;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) m_known[i][a] = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rxp = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_wa[i] = 0; m_ra[i] = 0; m_tx[i] = 1'b0; m_dout[i] = 8'h00;
        m_dknown[i] = 1'b1; m_pend[i] = 1'b0;
      end
    end else begin
      bit acc;
      int p;
      acc   = rx_valid && !m_rxp;
      m_rxp = rx_valid;
      p     = int'(din[7:0]);
      for (int i = 0; i < 2; i++) begin
        if (m_pend[i]) begin
          m_tx[i] = 1'b1; m_dout[i] = m_pval[i]; m_dknown[i] = m_pknown[i]; m_pend[i] = 1'b0;
        end else if (acc) begin
          m_tx[i] = 1'b0;
          case (din[9:8])
            2'b00: m_wa[i] = p;
            2'b01: begin
              if (m_wa[i] < depth[i]) begin
                m_mem[i][m_wa[i]]   = din[7:0];
                m_known[i][m_wa[i]] = 1'b1;
              end
`ifdef SPI_RAM_AUTOINC_EN
              m_wa[i] = nxt(m_wa[i], depth[i]);
`endif
            end
            2'b10: m_ra[i] = p;
            default: begin
              m_pend[i] = 1'b1;
              if (m_ra[i] < depth[i]) begin
                m_pval[i] = m_mem[i][m_ra[i]]; m_pknown[i] = m_known[i][m_ra[i]];
              end else begin
                m_pval[i] = 8'h00; m_pknown[i] = 1'b1;
              end
`ifdef SPI_RAM_AUTOINC_EN
              m_ra[i] = nxt(m_ra[i], depth[i]);
`endif
            end
          endcase
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_inst(int i, logic t, logic [7:0] d);
    check($sformatf("tx_valid[%0d]", i), 32'(t), 32'(m_tx[i]));
    if (m_tx[i] && m_dknown[i]) check($sformatf("dout[%0d]", i), 32'(d), 32'(m_dout[i]));
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      compare_inst(0, tx0, dout0);
      compare_inst(1, tx1, dout1);
    end
  endtask

  task automatic send(logic [1:0] c, logic [7:0] p, int hold, int gap);
    din = {c, p};
    rx_valid = 1'b1;
    repeat (hold) tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic read_check(string name, logic [7:0] a, logic [7:0] e0, logic [7:0] e1);
    send(2'b10, a, 1, 1);
    send(2'b11, 8'h00, 1, 3);
    check({name, " tx0"}, 32'(tx0), 32'd1);
    check({name, " dout0"}, 32'(dout0), 32'(e0));
    check({name, " tx1"}, 32'(tx1), 32'd1);
    check({name, " dout1"}, 32'(dout1), 32'(e1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset tx0", 32'(tx0), 32'd0);
    check("reset dout0", 32'(dout0), 32'h0);
    check("reset tx1", 32'(tx1), 32'd0);
    rst = 1'b0;
    tick();

    // Basic write then read back
    send(2'b00, 8'h3A, 1, 1);
    send(2'b01, 8'hC5, 1, 1);
    read_check("t1", 8'h3A, 8'hC5, 8'hC5);

    // Long rx_valid hold must produce a single write
    send(2'b00, 8'h01, 1, 1);
    send(2'b01, 8'h5A, 1, 1);
    send(2'b00, 8'h00, 1, 1);
    send(2'b01, 8'h77, 12, 1);
    read_check("t2 m0", 8'h00, 8'h77, 8'h77);
    read_check("t2 m1", 8'h01, 8'h5A, 8'h5A);

    // Accepted command while tx_valid high drops it next cycle and still executes
    send(2'b00, 8'h10, 1, 1);
    check("t3 tx0 fall", 32'(tx0), 32'd0);
    send(2'b01, 8'hE4, 1, 1);
    read_check("t3", 8'h10, 8'hE4, 8'hE4);

    // Reset in READ clears outputs immediately; memory survives
    send(2'b10, 8'h3A, 1, 1);
    din = {2'b11, 8'h00};
    rx_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4 tx0", 32'(tx0), 32'd0);
    check("t4 dout0", 32'(dout0), 32'h0);
    check("t4 dout1", 32'(dout1), 32'h0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    read_check("t4 kept", 8'h3A, 8'hC5, 8'hC5);

    // 0x80 is in range for depth 256, out of range for depth 128 (no aliasing onto 0x00)
    send(2'b00, 8'h80, 1, 1);
    send(2'b01, 8'hAA, 1, 1);
    read_check("t6", 8'h80, 8'hAA, 8'h00);
    read_check("t6 alias", 8'h00, 8'h77, 8'h77);

`ifdef SPI_RAM_AUTOINC_EN
    send(2'b00, 8'hFF, 1, 1);
    send(2'b01, 8'h11, 1, 1);
    send(2'b01, 8'h22, 1, 1);
    read_check("t5 a", 8'hFF, 8'h11, 8'h00);
    send(2'b11, 8'h00, 1, 3);
    check("t5 b dout0", 32'(dout0), 32'h22);
    check("t5 b dout1", 32'(dout1), 32'h22);
`endif

    for (int n = 0; n < 500; n++) begin
      logic [1:0] c;
      logic [7:0] p;
      c = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: p = 8'h00;
        1: p = 8'h7F;
        2: p = 8'h80;
        3: p = 8'hFF;
        4: p = 8'hFE;
        default: p = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
      end
      send(c, p, $urandom_range(1, 4), $urandom_range(1, 3));
    end
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
